pixel_scanner: RTL
==================

PIXEL_SCANNER -- requirements
Module: pixel_scanner

Interface
REQ-001 SHALL have parameter COORD_W, default 16, width of bounding-box and pixel coordinates.
REQ-002 SHALL have parameter SCREEN_MAX, default 255, largest legal pixel coordinate on either axis.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 bbox_valid  input  1  one-cycle pulse; the four bbox ports are valid in that cycle.
REQ-006 bbox_x_min_int, bbox_x_max_int, bbox_y_min_int, bbox_y_max_int  input  COORD_W each  unsigned integer bbox limits, inclusive.
REQ-007 busy  output  1  high while a bbox is being scanned.
REQ-008 pix_x, pix_y  output  COORD_W each  current pixel coordinate.
REQ-009 pix_valid  output  1  pix_x/pix_y hold a pixel to be consumed.
REQ-010 pix_ready  input  1  downstream accepts the pixel when pix_valid && pix_ready.
REQ-011 done  output  1  one-cycle pulse after the last pixel of a bbox is accepted, or for an empty bbox.

Function
REQ-012 SHALL use states IDLE, SCAN and FIN.
REQ-013 IDLE -> SCAN on bbox_valid with a non-empty box: latch the clamped limits; pix_x = x_min and pix_y = y_min in the next cycle.
REQ-014 Each limit SHALL be clamped to SCREEN_MAX before latching; min > max on either axis, after clamping, is an empty box.
REQ-015 IDLE -> FIN on bbox_valid with an empty box; no pix_valid is produced.
REQ-016 In SCAN, pix_valid SHALL be 1, and pix_x/pix_y SHALL hold steady while pix_ready is 0.
REQ-017 On a handshake with pix_x < x_max, pix_x SHALL increment by 1.
REQ-018 On a handshake with pix_x == x_max and pix_y < y_max, pix_x SHALL return to x_min and pix_y SHALL increment by 1.
REQ-019 On a handshake at (x_max, y_max), the state SHALL go SCAN -> FIN.
REQ-020 FIN SHALL assert done for exactly one cycle, then go to IDLE.
REQ-021 Throughput SHALL be one pixel per cycle when pix_ready is held high; a box of W*H pixels completes W*H cycles after the first pix_valid.
REQ-022 busy SHALL be 1 in SCAN and FIN, and 0 in IDLE.
REQ-023 bbox_valid SHALL be ignored unless the state is IDLE (no queuing).
REQ-024 Coordinate arithmetic SHALL be unsigned COORD_W; since coordinates are clamped to SCREEN_MAX, an increment never wraps.

Reset
REQ-025 While rst is high: state = IDLE; pix_x, pix_y, busy, pix_valid and done = 0; latched limits = 0.
REQ-026 rst asserted mid-scan SHALL abandon the box with no done pulse; the first cycle after rst deasserts SHALL be IDLE.

Configuration
REQ-027 Macro PIXEL_SCANNER_PIX_CNT_EN, when defined, SHALL add output pix_count (2*COORD_W wide): cleared on entry to SCAN, incremented on each handshake, and held after done until the next accepted bbox.
REQ-028 When the macro is undefined, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package raster_pkg SHALL hold the scan state enum typedef and the SCREEN_MAX default constant, shared with other raster stages.
REQ-030 Sub-module scan_axis_ctr SHALL implement one axis counter (load min, increment, at-max flag) and be instantiated twice; all other logic stays in pixel_scanner.

Verification
REQ-031 Box x 2..4, y 5..6, pix_ready=1: the bench SHALL see (2,5)(3,5)(4,5)(2,6)(3,6)(4,6) on consecutive cycles, then done one cycle after the last pixel.
REQ-032 Box x 10..10, y 10..10: the bench SHALL see exactly one pixel (10,10), then done; with PIXEL_SCANNER_PIX_CNT_EN, pix_count = 1.
REQ-033 Box x_min=7, x_max=3: the bench SHALL see no pix_valid, done one cycle after bbox_valid, and busy high for that single cycle.
REQ-034 Box x 250..300, y 0..0: x SHALL clamp to 255, giving pixels (250,0) through (255,0) — 6 pixels.
REQ-035 Box 0..1 x 0..1 with pix_ready toggling 1,0,0,1,...: coordinates SHALL hold while ready is low, all 4 pixels are delivered once each, and a second bbox_valid sent mid-scan SHALL be ignored.
REQ-036 rst pulsed while at (3,5) of the REQ-031 box: outputs SHALL be 0 the next cycle with no done pulse, and a new box SHALL then scan from its own minimum corner.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster-stage types: scan state encoding and the default screen limit.
package raster_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } scan_state_e;

    localparam int SCREEN_MAX_DEFAULT = 255;

endpackage

// File: rtl/scan_axis_ctr.sv
// One axis of the raster walk: loads a start coordinate, steps by one, flags the axis limit.
module scan_axis_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_r;

    // Coordinate register; load has priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (inc) begin
            count_r <= count_r + W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count  = count_r;
    assign at_max = (count_r == max_val);

endmodule

// File: rtl/pixel_scanner.sv
// Walks every pixel of an inclusive bounding box, row by row, over a valid/ready stream.
// Optional macro PIXEL_SCANNER_PIX_CNT_EN adds a pix_count output of accepted pixels.
module pixel_scanner
    import raster_pkg::*;
#(
    parameter int COORD_W    = 16,
    parameter int SCREEN_MAX = SCREEN_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bbox_valid,
    input  logic [COORD_W-1:0] bbox_x_min_int,
    input  logic [COORD_W-1:0] bbox_x_max_int,
    input  logic [COORD_W-1:0] bbox_y_min_int,
    input  logic [COORD_W-1:0] bbox_y_max_int,
    output logic               busy,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               done
`ifdef PIXEL_SCANNER_PIX_CNT_EN
    ,
    output logic [2*COORD_W-1:0] pix_count
`endif
);

    localparam logic [COORD_W-1:0] SCREEN_MAX_C = COORD_W'(SCREEN_MAX);

    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v);
        if (v > SCREEN_MAX_C) begin
            clamp_coord = SCREEN_MAX_C;
        end else begin
            clamp_coord = v;
        end
    endfunction

    scan_state_e state_r, state_n;

    logic [COORD_W-1:0] x_min_r, x_max_r, y_min_r, y_max_r;
    logic [COORD_W-1:0] x_min_c_s, x_max_c_s, y_min_c_s, y_max_c_s;
    logic               empty_s, start_s, hs_s;
    logic               x_at_max_s, y_at_max_s;
    logic               x_load_s, x_inc_s, y_inc_s;
    logic [COORD_W-1:0] x_load_val_s;
    logic               busy_r, pix_valid_r, done_r;

    assign x_min_c_s = clamp_coord(bbox_x_min_int);
    assign x_max_c_s = clamp_coord(bbox_x_max_int);
    assign y_min_c_s = clamp_coord(bbox_y_min_int);
    assign y_max_c_s = clamp_coord(bbox_y_max_int);
    assign empty_s   = (x_min_c_s > x_max_c_s) || (y_min_c_s > y_max_c_s);

    // Next-state and axis-counter control.
    always_comb begin
        state_n      = state_r;
        start_s      = 1'b0;
        hs_s         = 1'b0;
        x_load_s     = 1'b0;
        x_load_val_s = x_min_r;
        x_inc_s      = 1'b0;
        y_inc_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bbox_valid) begin
                    if (empty_s) begin
                        state_n = FIN;
                    end else begin
                        state_n      = SCAN;
                        start_s      = 1'b1;
                        x_load_s     = 1'b1;
                        x_load_val_s = x_min_c_s;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SCAN: begin
                hs_s = pix_ready;
                if (pix_ready) begin
                    // End of row wraps x back to the left edge and advances y.
                    x_load_s = x_at_max_s;
                    x_inc_s  = !x_at_max_s;
                    y_inc_s  = x_at_max_s && !y_at_max_s;
                    if (x_at_max_s && y_at_max_s) begin
                        state_n = FIN;
                    end else begin
                        state_n = SCAN;
                    end
                end else begin
                    state_n = SCAN;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, registered status flags and latched box limits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            pix_valid_r <= 1'b0;
            done_r      <= 1'b0;
            x_min_r     <= '0;
            x_max_r     <= '0;
            y_min_r     <= '0;
            y_max_r     <= '0;
        end else begin
            state_r     <= state_n;
            busy_r      <= (state_n != IDLE);
            pix_valid_r <= (state_n == SCAN);
            done_r      <= (state_n == FIN);
            if (start_s) begin
                x_min_r <= x_min_c_s;
                x_max_r <= x_max_c_s;
                y_min_r <= y_min_c_s;
                y_max_r <= y_max_c_s;
            end else begin
                x_min_r <= x_min_r;
                x_max_r <= x_max_r;
                y_min_r <= y_min_r;
                y_max_r <= y_max_r;
            end
        end
    end

    scan_axis_ctr #(.W(COORD_W)) u_x_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (x_load_s),
        .load_val (x_load_val_s),
        .inc      (x_inc_s),
        .max_val  (x_max_r),
        .count    (pix_x),
        .at_max   (x_at_max_s)
    );

    scan_axis_ctr #(.W(COORD_W)) u_y_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_s),
        .load_val (y_min_c_s),
        .inc      (y_inc_s),
        .max_val  (y_max_r),
        .count    (pix_y),
        .at_max   (y_at_max_s)
    );

    assign busy      = busy_r;
    assign pix_valid = pix_valid_r;
    assign done      = done_r;

`ifdef PIXEL_SCANNER_PIX_CNT_EN
    logic [2*COORD_W-1:0] pix_count_r;

    // Accepted-pixel count; held after done until the next box starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count_r <= '0;
        end else if (start_s) begin
            pix_count_r <= '0;
        end else if (hs_s) begin
            pix_count_r <= pix_count_r + (2*COORD_W)'(1'b1);
        end else begin
            pix_count_r <= pix_count_r;
        end
    end

    assign pix_count = pix_count_r;
`endif

endmodule
